// File: rtl/prio_arbiter_rr.sv
// prio_arbiter_rr
// Registered N-way request arbiter with a valid/ready grant handshake.
// Picks one active requester per decision, either by fixed priority
// (highest index wins) or round-robin (the last winner is least favoured),
// and holds the grant until downstream accepts it.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         request vector, bit i = requester i active
//   mode        0 = fixed priority, 1 = round-robin
//   gnt_ready   downstream accepts the presented grant
//   gnt_valid   a grant is presented
//   gnt_idx     index of the granted requester
//   gnt_onehot  one-hot grant, zero while gnt_valid is low
//   req_count   registered popcount of req
//
// state | meaning
// IDLE  | no grant presented, waiting for any request
// GRANT | grant presented and frozen until accepted
module prio_arbiter_rr #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot,
  output logic [CNT_W-1:0] req_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     onehot;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] win;
  logic             any_cand;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (state_q == GRANT) && (idx_q == IDX_W'(i));
    end
  end

  // While a grant is presented, the only decision that matters is the one
  // taken on accept: the granted bit is excluded and the round-robin search
  // starts just below it, since it becomes last_ptr at that same edge.
  always_comb begin
    cand = req & ~onehot;
    base = (state_q == GRANT) ? idx_q : last_ptr_q;
  end

  always_comb begin
    int p;
    win = '0;
    p   = 0;
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) win = IDX_W'(i);
      end
    end else begin
      // k is the search rank (0 = searched first); scanning from the last
      // rank to the first lets the earliest-ranked hit overwrite the rest.
      // Position wraps modulo N, not modulo 2^IDX_W.
      for (int k = N - 1; k >= 0; k--) begin
        p = int'(base) + N - 1 - k;
        if (p >= N) p = p - N;
        if (cand[p]) win = IDX_W'(p);
      end
    end
    any_cand = |cand;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_cand) begin
          state_d = GRANT;
          idx_d   = win;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          last_ptr_d = idx_q;
          if (any_cand) idx_d = win;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + CNT_W'(req[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_ptr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot;
  assign req_count  = cnt_q;

endmodule

// File: doc/prio_arbiter_rr.md
Name: prio_arbiter_rr

Overview:
Parametrised N-way request arbiter and encoder. It is the registered, handshaked successor to the 4-bit combinational priority encoder. Each cycle it picks one active requester using either fixed priority (highest index wins) or round-robin priority. It registers the winner as an index plus a one-hot grant, and holds that grant until downstream accepts it. It sits between request sources (DMA channels, interrupt lines) and a shared resource.

Parameters:
N, 8, number of requesters; legal range 1..64.
IDX_W, derived = max(1, clog2(N)), width of the grant index (localparam, not overridable).
CNT_W, derived = clog2(N+1), width of the request count (localparam).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit i = requester i active
mode  input  1  0 = fixed priority (index N-1 highest); 1 = round-robin
gnt_ready  input  1  downstream accepts the current grant
gnt_valid  output  1  a grant is presented
gnt_idx  output  IDX_W  index of the granted requester
gnt_onehot  output  N  one-hot grant; all zero when gnt_valid=0
req_count  output  CNT_W  registered popcount of req

Behaviour:
- Async reset (rst_n low): gnt_valid=0, gnt_idx=0, gnt_onehot=0, req_count=0, last_ptr=0, state=IDLE. Asserting reset mid-grant drops the grant immediately. No handshake is reported for the dropped grant.
- Accept event = gnt_valid & gnt_ready at a rising edge.
- States:
  - IDLE (gnt_valid=0).
  - GRANT (gnt_valid=1).
- IDLE -> GRANT: at the first edge where req != 0. Latency is 1 cycle from req sampled high to gnt_valid high.
- IDLE stays IDLE while req == 0.
- GRANT, no accept: gnt_idx and gnt_onehot are frozen. Changes on req (including withdrawal of the granted bit) and on mode are ignored.
- GRANT, accept:
  - last_ptr <- gnt_idx, in both modes.
  - The candidate set is req with bit gnt_idx masked off.
  - If the candidate set is non-zero, the new winner is registered at the same edge: back-to-back grants, no bubble.
  - Otherwise go to IDLE.
- Fixed priority: winner = highest set index of the candidates.
- Round-robin:
  - Search order is descending, starting at (last_ptr-1) mod N, wrapping through N-1, and ending at last_ptr.
  - The last winner is therefore lowest priority.
  - With last_ptr=0 after reset, round-robin order equals fixed order.
- Wrap arithmetic is modulo N, not 2^IDX_W. For non-power-of-2 N, index N-1 follows index 0 going downward.
- mode is sampled only at edges where a new winner is computed.
- N=1: gnt_idx is tied 0. Grant follows req[0] with the same handshake.
- req_count: popcount(req) registered every edge regardless of state. Range is 0..N.
- Invariants:
  - gnt_onehot == (gnt_valid ? 1<<gnt_idx : 0).
  - At most one bit of gnt_onehot is set.
  - gnt_idx < N.

Test Plan:
- N=8, mode=0, req=8'b0010_0110, gnt_ready=0 -> one edge later gnt_valid=1, gnt_idx=5, gnt_onehot=8'h20, req_count=3.
- N=8, mode=1, req=8'hFF held, gnt_ready=1 continuously -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 with gnt_valid high every cycle (no bubbles).
- N=8, mode=0, req=8'h80 then gnt_ready=0 for 3 cycles while req changes to 8'h01 -> gnt_idx stays 7 for all 3 cycles. After gnt_ready=1: next gnt_idx=0. The cycle after that accept, with req=0, gnt_valid=0.
- N=8, mode=0, req=8'h81 held, gnt_ready=1 -> grants 7, 0, 7, 0 … (granted bit masked on accept). With mode=1 the same sequence results.
- N=5, mode=1, req=5'b10001, gnt_ready=1 -> gnt_idx 4, 0, 4, 0 (modulo-5 wrap). Check gnt_idx never exceeds 4.
- Grant active with gnt_idx=3, then rst_n pulsed low asynchronously mid-cycle -> outputs 0 immediately. After release with req=8'h09 and mode=1 -> gnt_idx=3, showing last_ptr was reset to 0.
